// File: rtl/display_pkg.sv
// Shared types and glyph tables for the result display path.
package display_pkg;

  // Width of the packed BCD field (hundreds, tens, units).
  localparam int BCD_W = 12;

  // Per-digit content code held in the display registers.
  typedef enum logic [3:0] {
    D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    BLANK, GLYPH_Q, GLYPH_R
  } digit_code_e;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_Q     = 7'h18;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Map a digit code to its segment pattern.
  function automatic logic [6:0] code_to_seg(input digit_code_e code);
    logic [6:0] seg;
    case (code)
      D0:      seg = SEG_0;
      D1:      seg = SEG_1;
      D2:      seg = SEG_2;
      D3:      seg = SEG_3;
      D4:      seg = SEG_4;
      D5:      seg = SEG_5;
      D6:      seg = SEG_6;
      D7:      seg = SEG_7;
      D8:      seg = SEG_8;
      D9:      seg = SEG_9;
      GLYPH_Q: seg = SEG_Q;
      GLYPH_R: seg = SEG_R;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // A BCD nibble above 9 cannot occur for supported values; show it blank.
  function automatic digit_code_e nib_to_code(input logic [3:0] nib);
    return (nib <= 4'd9) ? digit_code_e'(nib) : BLANK;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock.
module bcd_dabble_seq
  import display_pkg::*;
#(
  parameter int VAL_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int SR_W  = BCD_W + VAL_W;
  localparam int CNT_W = $clog2(VAL_W + 1);

  conv_state_e      state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d, sr_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  generate
    for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = sr_q[VAL_W + 4*gi +: 4];
      assign sr_adj[VAL_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate
  assign sr_adj[VAL_W-1:0] = sr_q[VAL_W-1:0];

  // Next-state logic; a start in any state reloads and restarts from iteration 0.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (start) begin
      state_d = ST_SHIFT;
      sr_d    = {{BCD_W{1'b0}}, value};
      cnt_d   = CNT_W'(VAL_W);
    end else begin
      case (state_q)
        ST_SHIFT: begin
          sr_d  = {sr_adj[SR_W-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, shift register and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/result_display_mux.sv
// Captures divider results, converts the selected one to decimal and scans it
// onto a 4-digit common-anode 7-segment display.
module result_display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int VAL_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] q_in,
  input  logic [VAL_W-1:0] r_in,
  input  logic             div_done,
  input  logic             sel_r,
  output logic [3:0]       anodo,
  output logic [6:0]       seven,
  output logic             busy
);

  localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [VAL_W-1:0] q_lat_q, q_lat_d, r_lat_q, r_lat_d, conv_val;
  logic             sel_prev_q, sel_conv_q, sel_conv_d;
  logic             captured_q, captured_d, pending_q, pending_d;
  logic             lit_q, lit_d, start, sel_chg, conv_busy, conv_done;
  logic [BCD_W-1:0] bcd;
  digit_code_e      digit_q [4];
  digit_code_e      digit_d [4];
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [1:0]       scan_q, scan_d;
  logic [3:0]       anodo_q, anodo_d;
  logic [6:0]       seven_q, seven_d;

  bcd_dabble_seq #(.VAL_W(VAL_W)) u_dabble (
    .clk   (clk),
    .rst_n (rst),
    .start (start),
    .value (conv_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Capture, start arbitration and pending-restart tracking.
  always_comb begin
    sel_chg    = sel_r ^ sel_prev_q;
    q_lat_d    = div_done ? q_in : q_lat_q;
    r_lat_d    = div_done ? r_in : r_lat_q;
    captured_d = captured_q | div_done;
    // sel_r changes only matter once a result exists to show.
    start      = div_done | (captured_q & ~conv_busy & (sel_chg | pending_q));
    conv_val   = sel_r ? r_lat_d : q_lat_d;
    sel_conv_d = start ? sel_r : sel_conv_q;
    pending_d  = pending_q;
    if (start) pending_d = 1'b0;
    else if (sel_chg && conv_busy) pending_d = 1'b1;
  end

  // Digit codes written when a conversion commits, with leading-zero blanking.
  always_comb begin
    digit_d = digit_q;
    lit_d   = lit_q;
    if (conv_done) begin
      digit_d[3] = sel_conv_q ? GLYPH_R : GLYPH_Q;
      digit_d[2] = (bcd[11:8] == 4'd0) ? BLANK : nib_to_code(bcd[11:8]);
      digit_d[1] = (bcd[11:4] == 8'd0) ? BLANK : nib_to_code(bcd[7:4]);
      digit_d[0] = nib_to_code(bcd[3:0]);
      lit_d      = 1'b1;
    end
  end

  // Refresh counter, scan index and the registered anode/segment drive.
  always_comb begin
    rc_d    = (rc_q == RC_W'(REFRESH_DIV - 1)) ? '0 : rc_q + RC_W'(1);
    scan_d  = (rc_q == RC_W'(REFRESH_DIV - 1)) ? scan_q + 2'd1 : scan_q;
    anodo_d = lit_q ? ~(4'b0001 << scan_q) : 4'b1111;
    seven_d = lit_q ? code_to_seg(digit_q[scan_q]) : SEG_BLANK;
  end

  // All top-level state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_lat_q    <= '0;
      r_lat_q    <= '0;
      sel_prev_q <= 1'b0;
      sel_conv_q <= 1'b0;
      captured_q <= 1'b0;
      pending_q  <= 1'b0;
      lit_q      <= 1'b0;
      for (int i = 0; i < 4; i++) digit_q[i] <= BLANK;
      rc_q       <= '0;
      scan_q     <= '0;
      anodo_q    <= 4'b1111;
      seven_q    <= SEG_BLANK;
    end else begin
      q_lat_q    <= q_lat_d;
      r_lat_q    <= r_lat_d;
      sel_prev_q <= sel_r;
      sel_conv_q <= sel_conv_d;
      captured_q <= captured_d;
      pending_q  <= pending_d;
      lit_q      <= lit_d;
      digit_q    <= digit_d;
      rc_q       <= rc_d;
      scan_q     <= scan_d;
      anodo_q    <= anodo_d;
      seven_q    <= seven_d;
    end
  end

  assign anodo = anodo_q;
  assign seven = seven_q;
  assign busy  = conv_busy;

endmodule

// File: tb/tb_result_display_mux.sv
// Directed bench for result_display_mux with an expected-display scoreboard.
module tb_result_display_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] q_in = '0;
  logic [6:0] r_in = '0;
  logic       div_done = 1'b0;
  logic       sel_r = 1'b0;
  logic [3:0] anodo;
  logic [6:0] seven;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  // Expected glyphs packed {digit3, digit2, digit1, digit0}.
  logic [3:0][6:0] sb [$];
  logic [3:0][6:0] cur;
  logic [3:0][6:0] prev;

  result_display_mux #(.REFRESH_DIV(4), .VAL_W(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .q_in     (q_in),
    .r_in     (r_in),
    .div_done (div_done),
    .sel_r    (sel_r),
    .anodo    (anodo),
    .seven    (seven),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] dg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0][6:0] model(input int v, input logic s);
    logic [3:0][6:0] g;
    int h, t, u;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    g[3] = s ? 7'h2F : 7'h18;
    g[2] = (h == 0) ? 7'h7F : dg(h);
    g[1] = (h == 0 && t == 0) ? 7'h7F : dg(t);
    g[0] = dg(u);
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_done(input int q, input int r, input bit supersede);
    if (supersede && sb.size() > 0) void'(sb.pop_back());
    sb.push_back(model(sel_r ? r : q, sel_r));
    $display("txn div_done q=%0d r=%0d sel_r=%0d", q, r, sel_r);
    q_in = 7'(q); r_in = 7'(r); div_done = 1'b1;
    tick();
    div_done = 1'b0;
  endtask

  task automatic toggle_sel();
    sel_r = ~sel_r;
    sb.push_back(model(sel_r ? int'(r_in) : int'(q_in), sel_r));
    $display("txn sel_r -> %0d", sel_r);
    tick();
  endtask

  task automatic expect_busy(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic pop_exp(output logic [3:0][6:0] g);
    chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) g = sb.pop_front();
    else g = '1;
  endtask

  function automatic int anode_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check_scan(input logic [3:0][6:0] g, input string tag);
    int cnt [4];
    int k;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      k = anode_idx(anodo);
      chk({tag, "_onehot"}, {31'd0, k >= 0}, 32'd1);
      if (k >= 0) begin
        cnt[k]++;
        chk({tag, "_seg"}, {25'd0, seven}, {25'd0, g[k]});
      end
    end
    for (int i = 0; i < 4; i++) chk({tag, "_dwell"}, cnt[i], 32'd4);
    $display("txn %s scan %h %h %h %h", tag, g[3], g[2], g[1], g[0]);
  endtask

  task automatic check_dark(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {20'd0, anodo, seven, busy}, {20'd0, 4'hF, 7'h7F, 1'b0});
    end
  endtask

  initial begin
    // 1: reset and dark display
    #2 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("reset_out", {20'd0, anodo, seven, busy}, {20'd0, 4'hF, 7'h7F, 1'b0});
    rst = 1'b1;
    check_dark(20, "dark_after_reset");

    // 2: first result, quotient 1
    pulse_done(1, 0, 0);
    expect_busy(8, "busy_q1");
    pop_exp(cur);
    check_scan(cur, "q1");

    // 3: 127/45, then show the remainder
    pulse_done(127, 45, 0);
    expect_busy(8, "busy_q127");
    pop_exp(cur);
    check_scan(cur, "q127");
    toggle_sel();
    expect_busy(8, "busy_r45");
    pop_exp(cur);
    check_scan(cur, "r45");

    // 4: back to quotient, then a restart mid-SHIFT
    toggle_sel();
    expect_busy(8, "busy_q127b");
    pop_exp(cur);
    check_scan(cur, "q127b");
    pulse_done(6, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("busy_pre_restart", {31'd0, busy}, 32'd1);
      tick();
    end
    pulse_done(3, 0, 1);
    expect_busy(8, "busy_restart");
    pop_exp(cur);
    check_scan(cur, "q3");

    // 5: sel_r toggled mid-SHIFT -> old selection commits, then pending restart
    pulse_done(58, 9, 0);
    tick();
    tick();
    toggle_sel();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("busy_pending", {31'd0, busy}, {31'd0, (i < 5) || (i >= 6 && i < 14)});
      if (i == 5) pop_exp(prev);
      if (i >= 6 && i < 14 && anode_idx(anodo) >= 0)
        chk("old_sel_shown", {25'd0, seven}, {25'd0, prev[anode_idx(anodo)]});
    end
    pop_exp(cur);
    check_scan(cur, "r9");

    // 6: asynchronous reset mid-SHIFT
    pulse_done(99, 99, 0);
    tick();
    #3 rst = 1'b0;
    #1;
    chk("async_reset_out", {20'd0, anodo, seven, busy}, {20'd0, 4'hF, 7'h7F, 1'b0});
    void'(sb.pop_back());
    tick();
    tick();
    rst = 1'b1;
    check_dark(20, "dark_after_reset2");
    tick();
    pulse_done(99, 99, 0);
    expect_busy(8, "busy_r99");
    pop_exp(cur);
    check_scan(cur, "r99");

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
